// File: rtl/pcs_gb_pkg.sv
// Shared constants and helpers for the lane up-converting gearbox.
// Fill counter sizing and lane slice offsets live here so top and lanes agree.
package pcs_gb_pkg;

  localparam int IN_W_25G     = 48;
  localparam int OUT_W_25G    = 64;
  localparam int LANE_NUM_25G = 4;

  // Width able to hold 0..(in_w+out_w) inclusive.
  function automatic int gb_cnt_w(input int in_w, input int out_w);
    int cap;
    int w;
    cap = in_w + out_w;
    w   = 1;
    while ((1 << w) <= cap) w++;
    return w;
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/gb_lane_shift.sv
// One lane of the gearbox: IN_W+OUT_W bit shift buffer, drained LSB-first,
// with new words inserted just above the post-drain residue.
module gb_lane_shift #(
  parameter int   IN_W    = 48,
  parameter int   OUT_W   = 64,
  parameter int   CW      = 7,
  parameter logic PAD_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             accept,
  input  logic             drain,
  input  logic             clr,
  input  logic [CW-1:0]    wpos,
  input  logic [IN_W-1:0]  in_word,
  input  logic [OUT_W-1:0] pad_mask,
  output logic [OUT_W-1:0] out_word
);

  localparam int CAP = IN_W + OUT_W;

  logic [CAP-1:0] sh_q, sh_d;
  logic [CAP-1:0] shifted, ins, msk;

  // Bits above the residue are kept zero so a padded flush word is clean.
  always_comb begin
    shifted = sh_q;
    if (clr)        shifted = '0;
    else if (drain) shifted = sh_q >> OUT_W;
    ins  = CAP'(in_word) << wpos;
    msk  = {{OUT_W{1'b0}}, {IN_W{1'b1}}} << wpos;
    sh_d = accept ? ((shifted & ~msk) | ins) : shifted;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sh_q <= '0;
    else          sh_q <= sh_d;
  end

  assign out_word = (sh_q[OUT_W-1:0] & ~pad_mask) | ({OUT_W{PAD_BIT}} & pad_mask);

endmodule

// File: rtl/gearbox_lanes_up.sv
// Lockstep multi-lane IN_W->OUT_W up-converting gearbox with flush-with-pad.
// Optional sticky protocol checker enabled by GBX_PROTO_CHECK_EN.
module gearbox_lanes_up
  import pcs_gb_pkg::*;
#(
  parameter int   LANE_NUM = LANE_NUM_25G,
  parameter int   IN_W     = IN_W_25G,
  parameter int   OUT_W    = OUT_W_25G,
  parameter logic PAD_BIT  = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 in_enable,
  output logic                                 out_idle,
  input  logic [LANE_NUM*IN_W-1:0]             in_data,
  input  logic                                 in_datavalid,
  input  logic                                 in_flush,
  output logic [LANE_NUM*OUT_W-1:0]            out_data,
  output logic                                 out_datavalid,
  input  logic                                 in_idle,
  output logic                                 empty_save,
  output logic [$clog2(IN_W+OUT_W+1)-1:0]      fill_lvl,
  output logic                                 proto_err
);

  localparam int CW = gb_cnt_w(IN_W, OUT_W);

  logic [CW-1:0]    fill_q, fill_d, after;
  logic             flush_pend_q, flush_pend_d;
  logic             full, part, drain, pad_em, accept;
  logic [OUT_W-1:0] pad_mask;

  always_comb begin
    full   = fill_q >= CW'(OUT_W);
    part   = (fill_q != '0) && !full;
    drain  = in_enable & in_idle & full;
    pad_em = in_enable & in_idle & flush_pend_q & part;
    after  = drain ? fill_q - CW'(OUT_W) : fill_q;
    // Room check: after + IN_W <= IN_W + OUT_W reduces to after <= OUT_W.
    out_idle = in_enable & !flush_pend_q & (after <= CW'(OUT_W));
    accept   = in_datavalid & out_idle;

    fill_d = pad_em ? '0 : (accept ? after + CW'(IN_W) : after);

    flush_pend_d = flush_pend_q;
    if (in_enable) begin
      if (flush_pend_q) flush_pend_d = !(pad_em || (fill_q == '0));
      else              flush_pend_d = in_flush;
    end

    pad_mask = '0;
    if (pad_em) pad_mask = {OUT_W{1'b1}} << fill_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign out_datavalid = drain | pad_em;
  assign empty_save    = (fill_q == '0);
  assign fill_lvl      = fill_q;

  for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
    gb_lane_shift #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .CW      (CW),
      .PAD_BIT (PAD_BIT)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .accept   (accept),
      .drain    (drain),
      .clr      (pad_em),
      .wpos     (after),
      .in_word  (in_data[lane_lsb(k, IN_W) +: IN_W]),
      .pad_mask (pad_mask),
      .out_word (out_data[lane_lsb(k, OUT_W) +: OUT_W])
    );
  end

`ifdef GBX_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;

  // Violating beats are already dropped because accept requires out_idle.
  always_comb begin
    proto_err_d = proto_err_q |
                  (in_enable & ((in_datavalid & !out_idle) | (in_flush & flush_pend_q)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) proto_err_q <= 1'b0;
    else          proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

`ifdef PCS_SIM
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (fill_q <= CW'(IN_W + OUT_W));
      assert (!out_datavalid || in_idle);
    end
  end
`endif

endmodule

// File: tb/tb_gearbox_lanes_up.sv
// Scoreboard bench: 4x48->64 directed scenarios plus 2x20->32 random stream.
module tb_gearbox_lanes_up;

  localparam bit PROTO_EXP =
`ifdef GBX_PROTO_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: 4 x 48 -> 64 ----------------
  logic         a_en = 1'b1, a_dv = 1'b0, a_flush = 1'b0, a_ridle = 1'b1;
  logic [191:0] a_data = '0;
  logic         a_oidle, a_vo, a_empty, a_perr;
  logic [255:0] a_out;
  logic [6:0]   a_fill;

  gearbox_lanes_up #(.LANE_NUM(4), .IN_W(48), .OUT_W(64), .PAD_BIT(1'b0)) u_a (
    .clk(clk), .reset_n(rst_n), .in_enable(a_en), .out_idle(a_oidle),
    .in_data(a_data), .in_datavalid(a_dv), .in_flush(a_flush),
    .out_data(a_out), .out_datavalid(a_vo), .in_idle(a_ridle),
    .empty_save(a_empty), .fill_lvl(a_fill), .proto_err(a_perr));

  // ---------------- DUT B: 2 x 20 -> 32 ----------------
  logic        b_en = 1'b1, b_dv = 1'b0, b_flush = 1'b0, b_ridle = 1'b1;
  logic [39:0] b_data = '0;
  logic        b_oidle, b_vo, b_empty, b_perr;
  logic [63:0] b_out;
  logic [5:0]  b_fill;

  gearbox_lanes_up #(.LANE_NUM(2), .IN_W(20), .OUT_W(32), .PAD_BIT(1'b0)) u_b (
    .clk(clk), .reset_n(rst_n), .in_enable(b_en), .out_idle(b_oidle),
    .in_data(b_data), .in_datavalid(b_dv), .in_flush(b_flush),
    .out_data(b_out), .out_datavalid(b_vo), .in_idle(b_ridle),
    .empty_save(b_empty), .fill_lvl(b_fill), .proto_err(b_perr));

  // ---------------- bitstream models + scoreboards ----------------
  logic [255:0] aq[$];
  logic [127:0] a_res[4];
  int           a_cnt = 0;
  logic [63:0]  bq[$];
  logic [63:0]  b_res[2];
  int           b_cnt = 0;

  task automatic a_push(input logic [191:0] d);
    logic [255:0] w;
    for (int k = 0; k < 4; k++) a_res[k] |= {80'b0, d[k*48 +: 48]} << a_cnt;
    a_cnt += 48;
    while (a_cnt >= 64) begin
      for (int k = 0; k < 4; k++) begin
        w[k*64 +: 64] = a_res[k][63:0];
        a_res[k] = a_res[k] >> 64;
      end
      aq.push_back(w);
      a_cnt -= 64;
    end
  endtask

  task automatic a_flush_model();
    logic [255:0] w;
    if (a_cnt > 0) begin
      for (int k = 0; k < 4; k++) begin
        w[k*64 +: 64] = a_res[k][63:0];
        a_res[k] = '0;
      end
      aq.push_back(w);
      a_cnt = 0;
    end
  endtask

  task automatic b_push(input logic [39:0] d);
    logic [63:0] w;
    for (int k = 0; k < 2; k++) b_res[k] |= {44'b0, d[k*20 +: 20]} << b_cnt;
    b_cnt += 20;
    while (b_cnt >= 32) begin
      for (int k = 0; k < 2; k++) begin
        w[k*32 +: 32] = b_res[k][31:0];
        b_res[k] = b_res[k] >> 32;
      end
      bq.push_back(w);
      b_cnt -= 32;
    end
  endtask

  task automatic b_flush_model();
    logic [63:0] w;
    if (b_cnt > 0) begin
      for (int k = 0; k < 2; k++) begin
        w[k*32 +: 32] = b_res[k][31:0];
        b_res[k] = '0;
      end
      bq.push_back(w);
      b_cnt = 0;
    end
  endtask

  // Monitors sample mid-cycle; inputs change just after posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      aq.delete(); bq.delete();
      for (int k = 0; k < 4; k++) a_res[k] = '0;
      for (int k = 0; k < 2; k++) b_res[k] = '0;
      a_cnt = 0; b_cnt = 0;
    end else begin
      if (a_vo) begin
        chk("a_vo_needs_idle", a_ridle, 1);
        if (aq.size() == 0) chk("a_unexpected_out", a_vo, 0);
        else                chk("a_out_data", a_out, aq.pop_front());
      end
      if (a_dv && a_oidle) a_push(a_data);
      if (a_flush && a_en) a_flush_model();

      chk("b_fill_max", b_fill <= 6'd52, 1);
      if (b_vo) begin
        if (bq.size() == 0) chk("b_unexpected_out", b_vo, 0);
        else                chk("b_out_data", b_out, bq.pop_front());
      end
      if (b_dv && b_oidle) b_push(b_data);
      if (b_flush && b_en) b_flush_model();
    end
  end

  // ---------------- drivers ----------------
  task automatic a_wait(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_dv = 1'b0; a_flush = 1'b0;
    end
  endtask

  // Presents one beat once out_idle allows it; held for exactly one edge.
  task automatic a_beat(input logic [191:0] d);
    int t = 0;
    do begin
      @(posedge clk); #1;
      a_dv = 1'b0; a_flush = 1'b0;
      #1; t++;
    end while (!a_oidle && t < 200);
    if (t >= 200) chk("a_beat_timeout", 0, 1);
    a_data = d; a_dv = 1'b1;
  endtask

  function automatic logic [191:0] all_lanes(input logic [47:0] l0);
    logic [191:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d[47:0] = l0;
    return d;
  endfunction

  logic [191:0] b1, b2;
  logic [255:0] frz;
  logic [47:0]  w48;

  initial begin
    #2;
    chk("rst_vo", a_vo, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_fill", a_fill, 0);
    chk("rst_oidle", a_oidle, 1);
    chk("rst_perr", a_perr, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: four beats, lane0 = AAAA_0000_000n; fill 48,32,16,0
    w48 = 48'hAAAA_0000_0001; b1 = all_lanes(w48);
    a_beat(b1); a_wait(2);
    chk("t1_fill1", a_fill, 48);
    w48 = 48'hAAAA_0000_0002; b2 = all_lanes(w48);
    a_beat(b2); a_wait(1);
    chk("t1_first_vo", a_vo, 1);
    chk("t1_word0_l0", a_out[63:0], {16'h0002, 48'hAAAA_0000_0001});
    a_wait(1);
    chk("t1_fill2", a_fill, 32);
    w48 = 48'hAAAA_0000_0003; a_beat(all_lanes(w48)); a_wait(2);
    chk("t1_fill3", a_fill, 16);
    w48 = 48'hAAAA_0000_0004; a_beat(all_lanes(w48)); a_wait(2);
    chk("t1_fill4", a_fill, 0);
    chk("t1_empty", a_empty, 1);

    // T3: backpressure; out_idle drops at fill 96, plus a protocol violation
    a_ridle = 1'b0;
    a_beat(all_lanes(48'h1111_2222_3333)); a_wait(2);
    a_beat(all_lanes(48'h4444_5555_6666)); a_wait(2);
    chk("t3_fill_hold", a_fill, 96);
    chk("t3_oidle_low", a_oidle, 0);
    chk("t3_vo_low", a_vo, 0);
    a_data = all_lanes(48'hDEAD_BEEF_0BAD); a_dv = 1'b1;
    a_wait(1); #1;
    chk("t3_perr", a_perr, PROTO_EXP);
    chk("t3_drop_fill", a_fill, 96);
    a_ridle = 1'b1;
    a_wait(3);
    chk("t3_fill_resume", a_fill, 32);
    a_beat(all_lanes(48'h7777_8888_9999)); a_wait(2);
    a_beat(all_lanes(48'hAAAA_BBBB_CCCC)); a_wait(2);
    chk("t3_fill_end", a_fill, 0);
    chk("t3_perr_sticky", a_perr, PROTO_EXP);

    // T4: in_enable low for 5 cycles with a full word pending
    b1 = all_lanes(48'h0123_4567_89AB);
    b2 = all_lanes(48'hFEDC_BA98_7654);
    for (int k = 0; k < 4; k++) frz[k*64 +: 64] = {b2[k*48 +: 16], b1[k*48 +: 48]};
    a_beat(b1); a_wait(2);
    a_beat(b2);
    @(posedge clk); #1;
    a_dv = 1'b0; a_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_fill_frozen", a_fill, 96);
      chk("t4_oidle", a_oidle, 0);
      chk("t4_vo", a_vo, 0);
      chk("t4_data_frozen", a_out, frz);
      @(posedge clk); #1;
    end
    a_en = 1'b1;
    a_wait(3);
    chk("t4_fill_resume", a_fill, 32);
    a_beat(all_lanes(48'h0F0F_0F0F_0F0F)); a_wait(2);
    a_beat(all_lanes(48'hF0F0_F0F0_F0F0)); a_wait(2);
    chk("t4_fill_end", a_fill, 0);

    // T2: three all-ones beats then flush -> two words + padded residue
    for (int i = 0; i < 3; i++) begin
      a_beat({192{1'b1}}); a_wait(2);
    end
    chk("t2_fill_res", a_fill, 16);
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    #1;
    chk("t2_oidle_pend", a_oidle, 0);
    chk("t2_pad_vo", a_vo, 1);
    chk("t2_pad_word", a_out[63:0], 64'h0000_0000_0000_FFFF);
    a_wait(2); #1;
    chk("t2_empty", a_empty, 1);
    chk("t2_fill0", a_fill, 0);
    chk("t2_oidle_back", a_oidle, 1);
    chk("a_queue_drained", aq.size(), 0);

    // Random 2x20->32 stream with random backpressure, then flush
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      b_dv = 1'b0; b_flush = 1'b0;
      b_ridle = ($urandom_range(0, 3) != 0);
      #1;
      b_data = 40'({$urandom, $urandom});
      b_dv   = ($urandom_range(0, 3) != 0) && b_oidle;
    end
    @(posedge clk); #1;
    b_dv = 1'b0; b_ridle = 1'b1; b_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("b_queue_drained", bq.size(), 0);
    chk("b_fill0", b_fill, 0);
    chk("b_empty", b_empty, 1);
    chk("b_oidle", b_oidle, 1);

    // Mid-operation reset discards residue and clears proto_err
    a_beat(all_lanes(48'h5A5A_5A5A_5A5A)); a_wait(1);
    chk("rst_mid_fill_pre", a_fill, 48);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_fill", a_fill, 0);
    chk("rst_mid_empty", a_empty, 1);
    chk("rst_mid_perr", a_perr, 0);
    chk("rst_mid_vo", a_vo, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    a_wait(2);
    chk("post_rst_fill", a_fill, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1);
  end

endmodule
